dlx_hazard_unit: RTL and testbench
==================================

Name: dlx_hazard_unit

Overview:
- Parametrised hazard and pipeline-control block for the DLX integer pipeline; sits beside the ID-stage decoder.
- Replaces the decoder's one-shot "kill after lw" signal with a tracked shadow of in-flight destinations in EX/MEM/WB.
- Produces load-use stalls, per-source forwarding selects for the EX operand muxes, and a configurable kill window after taken branches/jumps.

Parameters:
- NUM_SRC, 2, number of source-operand ports checked per ID instruction (1..3).
- REG_BITS, 5, register specifier width.
- LOAD_LATENCY, 1, load data is forwardable only once the load reaches stage index LOAD_LATENCY+1 (EX=1, MEM=2, WB=3); legal values 1..2.
- KILL_SLOTS, 1, instructions killed after a taken branch; 0 means delay-slot semantics, legal values 0..2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_BITS  packed source specifiers; port i occupies bits [i*REG_BITS +: REG_BITS].
- id_src_used  in  NUM_SRC  port i is actually read.
- id_rd  in  REG_BITS  destination register.
- id_regwr  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is lw/lb/lbu.
- id_branch_taken  in  1  branch/jump in ID resolved taken.
- stall  out  1  hold PC and IF/ID; inject bubble into EX (combinational).
- kill  out  1  ID instruction is squashed (registered).
- ex_fwd_sel  out  NUM_SRC*2  per-port EX mux select: 0 regfile, 1 MEM result, 2 WB result, 3 reserved (registered).

Behaviour:
- Shadow stages: EX, MEM and WB, each holding {valid, rd, regwr, is_load}.
- Shadow stages shift every cycle (EX->MEM->WB).
- EX loads the ID entry when id_valid & ~stall & ~kill; otherwise EX loads a bubble (valid=0).
- A shadow entry "produces r" when valid & regwr & rd==r & r!=0. r0 never matches.
- stall=1 when id_valid & ~kill & some used port i has src == r, and the youngest stage producing r is a load at stage index <= LOAD_LATENCY.
  - LOAD_LATENCY=1: one stall cycle for back-to-back lw/use.
  - LOAD_LATENCY=2: two stall cycles.
- Forwarding: on each non-stall cycle, ex_fwd_sel[i] is registered for the instruction entering EX.
  - Producer in EX now (reaches MEM next cycle): 1.
  - Producer in MEM now (reaches WB next cycle): 2.
  - Producer in WB only: 0, because the regfile writes first half-cycle.
  - Unused port: 0.
  - Youngest producer wins.
  - On stall or kill cycles, ex_fwd_sel registers 0 for all ports.
- Kill: kill_cnt (2 bits, reset 0); kill = (kill_cnt != 0).
  - When id_valid & id_branch_taken & ~stall & ~kill: kill_cnt <= KILL_SLOTS.
  - Otherwise it decrements while nonzero.
  - Killed instructions enter EX as bubbles and cannot raise stall or start a new kill window.
- Priority: reset > kill > stall. A branch that is itself stalled is ignored until the cycle it is not stalled.
- Reset values: all shadow valid=0, kill_cnt=0, ex_fwd_sel=0, kill=0; stall=0 because the shadow is empty.
- Reset asserted mid-stall or mid-kill clears both on the next edge.
- Every id_* input is ignored while id_valid=0.

Decomposition:
- Shared package dlx_pipe_pkg holds:
  - Stage index constants (STG_EX=1, STG_MEM=2, STG_WB=3).
  - Forward-select encodings FWD_RF/FWD_MEM/FWD_WB.
  - The shadow-entry struct {valid, rd, regwr, is_load}.
- One natural sub-module, dlx_src_match. It is instantiated NUM_SRC times.
  - Inputs: one source specifier plus the three shadow entries.
  - Outputs: a load-use hit and a forward select, using the youngest-wins priority.

Test Plan:
- lw r3 followed by add r4,r3,r5 (LOAD_LATENCY=1):
  - Cycle 1: stall=1 for exactly 1 cycle and EX gets a bubble.
  - Next cycle: add enters EX with ex_fwd_sel port0=2 (WB), port1=0.
- Same sequence with LOAD_LATENCY=2: stall=1 for 2 consecutive cycles, then ex_fwd_sel port0=0 (regfile).
- add r3 then sub r6,r3,r3, then or r7,r3,r0:
  - sub gets port0=1, port1=1, no stall.
  - or gets port0=2.
  - Two producers of r3 in EX and MEM: select 1.
- id_src=0 with a load to r0 in EX: stall=0 and ex_fwd_sel=0.
- Taken beqz with KILL_SLOTS=2: kill=1 for the next 2 cycles; a load-use pair inside that window raises no stall. With KILL_SLOTS=0, kill stays 0.
- Assert reset while stalled on a load: next cycle stall=0, kill=0, ex_fwd_sel=0, shadow empty, so an immediate consumer is not stalled.

Source files
------------

// File: rtl/dlx_pipe_pkg.sv
// Shared stage indices, forward-select encodings and the shadow-entry type
// used by the DLX hazard logic.
package dlx_pipe_pkg;

   localparam int STG_EX  = 1;
   localparam int STG_MEM = 2;
   localparam int STG_WB  = 3;

   // Widest register specifier a shadow entry can hold; narrower specifiers are zero-extended.
   localparam int RD_MAX_W = 8;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2,
      FWD_RSV = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
      logic                regwr;
      logic                is_load;
   } shadow_t;

   function automatic logic produces(input shadow_t e, input logic [RD_MAX_W-1:0] r);
      return e.valid & e.regwr & (e.rd == r) & (r != '0);
   endfunction

endpackage

// File: rtl/dlx_src_match.sv
// Matches one ID source specifier against the EX/MEM/WB shadow and reports
// a load-use hit plus the EX forward select; the youngest producer wins.
module dlx_src_match
   import dlx_pipe_pkg::*;
#(
   parameter int REG_BITS     = 5,
   parameter int LOAD_LATENCY = 1
)(
   input  logic [REG_BITS-1:0] i_src,
   input  logic                i_used,
   input  shadow_t             i_ex,
   input  shadow_t             i_mem,
   input  shadow_t             i_wb,
   output logic                o_load_hit,
   output fwd_sel_e            o_fwd_sel
);

   // A load at stage index <= LOAD_LATENCY has no forwardable data yet.
   localparam logic LD_BLOCK_EX  = (STG_EX  <= LOAD_LATENCY);
   localparam logic LD_BLOCK_MEM = (STG_MEM <= LOAD_LATENCY);
   localparam logic LD_BLOCK_WB  = (STG_WB  <= LOAD_LATENCY);

   logic [RD_MAX_W-1:0] w_src;

   assign w_src = RD_MAX_W'(i_src);

   always_comb begin
      o_load_hit = 1'b0;
      o_fwd_sel  = FWD_RF;
      if (i_used) begin
         if (produces(i_ex, w_src)) begin
            o_load_hit = i_ex.is_load & LD_BLOCK_EX;
            o_fwd_sel  = FWD_MEM;
         end else if (produces(i_mem, w_src)) begin
            o_load_hit = i_mem.is_load & LD_BLOCK_MEM;
            o_fwd_sel  = FWD_WB;
         end else if (produces(i_wb, w_src)) begin
            // Regfile writes in the first half-cycle, so a WB producer reads from the regfile.
            o_load_hit = i_wb.is_load & LD_BLOCK_WB;
            o_fwd_sel  = FWD_RF;
         end
      end
   end

endmodule

// File: rtl/dlx_hazard_unit.sv
// DLX hazard unit: tracks in-flight destinations in an EX/MEM/WB shadow and
// drives load-use stall, EX forwarding selects and the post-branch kill window.
module dlx_hazard_unit
   import dlx_pipe_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int REG_BITS     = 5,
   parameter int LOAD_LATENCY = 1,
   parameter int KILL_SLOTS   = 1
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         id_valid,
   input  logic [NUM_SRC*REG_BITS-1:0]  id_src,
   input  logic [NUM_SRC-1:0]           id_src_used,
   input  logic [REG_BITS-1:0]          id_rd,
   input  logic                         id_regwr,
   input  logic                         id_is_load,
   input  logic                         id_branch_taken,
   output logic                         stall,
   output logic                         kill,
   output logic [NUM_SRC*2-1:0]         ex_fwd_sel
);

   shadow_t                r_ex;
   shadow_t                r_mem;
   shadow_t                r_wb;
   logic [1:0]             r_kill_cnt;
   logic [NUM_SRC*2-1:0]   r_fwd_sel;

   shadow_t                w_id_entry;
   logic [NUM_SRC-1:0]     w_hit;
   logic [NUM_SRC*2-1:0]   w_sel;
   logic                   w_kill;
   logic                   w_stall;
   logic                   w_issue;
   logic                   w_branch;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_sel_e w_port_sel;

      dlx_src_match #(
         .REG_BITS     (REG_BITS),
         .LOAD_LATENCY (LOAD_LATENCY)
      ) u_match (
         .i_src      (id_src[g*REG_BITS +: REG_BITS]),
         .i_used     (id_src_used[g]),
         .i_ex       (r_ex),
         .i_mem      (r_mem),
         .i_wb       (r_wb),
         .o_load_hit (w_hit[g]),
         .o_fwd_sel  (w_port_sel)
      );

      assign w_sel[g*2 +: 2] = w_port_sel;
   end

   // Kill outranks stall: a squashed instruction cannot stall or open a new window.
   assign w_kill   = (r_kill_cnt != 2'd0);
   assign w_stall  = id_valid & ~w_kill & (|w_hit);
   assign w_issue  = id_valid & ~w_stall & ~w_kill;
   assign w_branch = id_valid & id_branch_taken & ~w_stall & ~w_kill;

   always_comb begin
      w_id_entry         = '0;
      w_id_entry.valid   = w_issue;
      w_id_entry.rd      = RD_MAX_W'(id_rd);
      w_id_entry.regwr   = id_regwr;
      w_id_entry.is_load = id_is_load;
   end

   // Only valid bits and control state are cleared; shadow payload is don't-care while invalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex.valid  <= 1'b0;
         r_mem.valid <= 1'b0;
         r_wb.valid  <= 1'b0;
         r_kill_cnt  <= 2'd0;
         r_fwd_sel   <= '0;
      end else begin
         r_ex      <= w_id_entry;
         r_mem     <= r_ex;
         r_wb      <= r_mem;
         r_fwd_sel <= w_issue ? w_sel : '0;
         if (w_branch) begin
            r_kill_cnt <= 2'(KILL_SLOTS);
         end else if (w_kill) begin
            r_kill_cnt <= r_kill_cnt - 2'd1;
         end
      end
   end

   assign stall      = w_stall;
   assign kill       = w_kill;
   assign ex_fwd_sel = r_fwd_sel;

endmodule

// File: tb/tb_dlx_hazard_unit.sv
// Scoreboard bench for dlx_hazard_unit: three configurations driven in lockstep,
// each checked against an issue-history reference model.
module tb_dlx_hazard_unit;

   localparam int LL_CFG [3] = '{1, 2, 1};
   localparam int KS_CFG [3] = '{1, 2, 0};

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [9:0] id_src;
   logic [1:0] id_src_used;
   logic [4:0] id_rd;
   logic       id_regwr;
   logic       id_is_load;
   logic       id_branch_taken;

   logic [2:0] dut_stall;
   logic [2:0] dut_kill;
   logic [3:0] dut_fwd [3];

   always #5 clk = ~clk;

   dlx_hazard_unit #(.NUM_SRC(2), .REG_BITS(5), .LOAD_LATENCY(1), .KILL_SLOTS(1)) u_dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
      .id_rd(id_rd), .id_regwr(id_regwr), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
      .stall(dut_stall[0]), .kill(dut_kill[0]), .ex_fwd_sel(dut_fwd[0]));

   dlx_hazard_unit #(.NUM_SRC(2), .REG_BITS(5), .LOAD_LATENCY(2), .KILL_SLOTS(2)) u_dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
      .id_rd(id_rd), .id_regwr(id_regwr), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
      .stall(dut_stall[1]), .kill(dut_kill[1]), .ex_fwd_sel(dut_fwd[1]));

   dlx_hazard_unit #(.NUM_SRC(2), .REG_BITS(5), .LOAD_LATENCY(1), .KILL_SLOTS(0)) u_dut2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
      .id_rd(id_rd), .id_regwr(id_regwr), .id_is_load(id_is_load), .id_branch_taken(id_branch_taken),
      .stall(dut_stall[2]), .kill(dut_kill[2]), .ex_fwd_sel(dut_fwd[2]));

   typedef struct {
      int         cfg;
      int         cyc;
      logic [4:0] rd;
      bit         wr;
      bit         ld;
   } hist_t;

   typedef struct {
      int         cfg;
      bit         st;
      bit         kl;
      logic [3:0] fw;
   } exp_t;

   hist_t      hist[$];
   exp_t       sb[$];
   int         kcnt [3];
   logic [3:0] efwd [3];
   int         cyc;
   int         n_checks;
   int         n_pass;

   task automatic chk(input string name, input int cfg, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cfg%0d: got %0h expected %0h (t=%0t)", name, cfg, act, exp, $time);
   endtask

   // Reference model: an instruction issued at model cycle t sits at stage index (now - t).
   task automatic drive(input bit v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd, input bit wr,
                        input bit ld, input bit br, input bit rs);
      id_valid        = v;
      id_src          = {s1, s0};
      id_src_used     = used;
      id_rd           = rd;
      id_regwr        = wr;
      id_is_load      = ld;
      id_branch_taken = br;
      reset           = rs;
      while (hist.size() > 0 && (cyc - hist[0].cyc) > 3) void'(hist.pop_front());
      for (int k = 0; k < 3; k++) begin
         bit         kil;
         bit         hit;
         bit         st;
         bit         iss;
         logic [3:0] sel;
         kil = (kcnt[k] != 0);
         hit = 1'b0;
         sel = '0;
         for (int p = 0; p < 2; p++) begin
            logic [4:0] src;
            int         bd;
            bit         bl;
            src = (p == 1) ? s1 : s0;
            bd  = 0;
            bl  = 1'b0;
            if (used[p] && src != 5'd0) begin
               foreach (hist[j]) begin
                  int d;
                  d = cyc - hist[j].cyc;
                  if (hist[j].cfg == k && hist[j].wr && hist[j].rd == src &&
                      d >= 1 && d <= 3 && (bd == 0 || d < bd)) begin
                     bd = d;
                     bl = hist[j].ld;
                  end
               end
            end
            if (bd != 0 && bl && bd <= LL_CFG[k]) hit = 1'b1;
            if (bd == 1) sel[p*2 +: 2] = 2'd1;
            else if (bd == 2) sel[p*2 +: 2] = 2'd2;
         end
         st  = v && !kil && hit;
         iss = v && !st && !kil;
         sb.push_back('{k, st, kil, efwd[k]});
         if (rs) begin
            kcnt[k] = 0;
            efwd[k] = '0;
            for (int j = hist.size() - 1; j >= 0; j--) if (hist[j].cfg == k) hist.delete(j);
         end else begin
            efwd[k] = iss ? sel : 4'd0;
            if (iss) hist.push_back('{k, cyc, rd, wr, ld});
            if (v && br && !st && !kil) kcnt[k] = KS_CFG[k];
            else if (kcnt[k] > 0) kcnt[k]--;
         end
      end
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic nop();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk("stall", e.cfg, 8'(dut_stall[e.cfg]), 8'(e.st));
         chk("kill",  e.cfg, 8'(dut_kill[e.cfg]),  8'(e.kl));
         chk("fwd",   e.cfg, 8'(dut_fwd[e.cfg]),   8'(e.fw));
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      for (int k = 0; k < 3; k++) begin
         kcnt[k] = 0;
         efwd[k] = '0;
      end
      reset = 1'b1; id_valid = 1'b0; id_src = '0; id_src_used = '0; id_rd = '0;
      id_regwr = 1'b0; id_is_load = 1'b0; id_branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // lw r3 ; add r4,r3,r5 held in ID
      drive(1, 0, 0, 2'b00, 3, 1, 1, 0, 0); settle();
      chk("rst_fwd", 0, 8'(dut_fwd[0]), 8'd0);
      chk("rst_kill", 1, 8'(dut_kill[1]), 8'd0);
      tick();
      drive(1, 3, 5, 2'b11, 4, 1, 0, 0, 0); settle();
      chk("lu_stall1", 0, 8'(dut_stall[0]), 8'd1);
      chk("lu_stall1", 1, 8'(dut_stall[1]), 8'd1);
      tick();
      drive(1, 3, 5, 2'b11, 4, 1, 0, 0, 0); settle();
      chk("lu_stall2", 0, 8'(dut_stall[0]), 8'd0);
      chk("lu_stall2", 1, 8'(dut_stall[1]), 8'd1);
      tick();
      drive(1, 3, 5, 2'b11, 4, 1, 0, 0, 0); settle();
      chk("lu_fwd_wb", 0, 8'(dut_fwd[0]), 8'h02);
      chk("lu_stall3", 1, 8'(dut_stall[1]), 8'd0);
      tick();
      nop(); settle();
      chk("lu_fwd_rf", 1, 8'(dut_fwd[1]), 8'h00);
      tick();

      // add r3 ; sub r6,r3,r3 ; or r7,r3,r0 ; then two producers of r3
      drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0); tick();
      drive(1, 3, 3, 2'b11, 6, 1, 0, 0, 0); settle();
      chk("alu_nostall", 0, 8'(dut_stall[0]), 8'd0);
      tick();
      drive(1, 3, 0, 2'b11, 7, 1, 0, 0, 0); settle();
      chk("sub_fwd", 0, 8'(dut_fwd[0]), 8'h05);
      tick();
      drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0); settle();
      chk("or_fwd", 0, 8'(dut_fwd[0]), 8'h02);
      tick();
      drive(1, 0, 0, 2'b00, 3, 1, 0, 0, 0); tick();
      drive(1, 3, 0, 2'b01, 9, 1, 0, 0, 0); tick();
      nop(); settle();
      chk("youngest", 0, 8'(dut_fwd[0]), 8'h01);
      tick();

      // load to r0 never matches
      drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0); tick();
      drive(1, 0, 0, 2'b11, 4, 1, 0, 0, 0); settle();
      chk("r0_stall", 0, 8'(dut_stall[0]), 8'd0);
      tick();
      nop(); settle();
      chk("r0_fwd", 0, 8'(dut_fwd[0]), 8'h00);
      tick();

      // taken branch, then lw/use pair inside the kill window
      drive(1, 0, 0, 2'b00, 0, 0, 0, 1, 0); tick();
      drive(1, 0, 0, 2'b00, 3, 1, 1, 0, 0); settle();
      chk("kill_a", 0, 8'(dut_kill[0]), 8'd1);
      chk("kill_a", 1, 8'(dut_kill[1]), 8'd1);
      chk("kill_a", 2, 8'(dut_kill[2]), 8'd0);
      tick();
      drive(1, 3, 0, 2'b01, 4, 1, 0, 0, 0); settle();
      chk("kill_b", 1, 8'(dut_kill[1]), 8'd1);
      chk("kill_nostall", 1, 8'(dut_stall[1]), 8'd0);
      chk("kill_b", 0, 8'(dut_kill[0]), 8'd0);
      chk("killed_ld", 0, 8'(dut_stall[0]), 8'd0);
      chk("slot_stall", 2, 8'(dut_stall[2]), 8'd1);
      tick();
      nop(); settle();
      chk("kill_end", 1, 8'(dut_kill[1]), 8'd0);
      tick();

      // reset while stalled on a load
      drive(1, 0, 0, 2'b00, 3, 1, 1, 0, 0); tick();
      drive(1, 3, 0, 2'b01, 4, 1, 0, 0, 1); settle();
      chk("pre_rst_stall", 0, 8'(dut_stall[0]), 8'd1);
      tick();
      drive(1, 3, 0, 2'b01, 4, 1, 0, 0, 0); settle();
      chk("post_rst_stall", 0, 8'(dut_stall[0]), 8'd0);
      chk("post_rst_stall", 1, 8'(dut_stall[1]), 8'd0);
      chk("post_rst_kill", 0, 8'(dut_kill[0]), 8'd0);
      chk("post_rst_fwd", 0, 8'(dut_fwd[0]), 8'h00);
      tick();

      for (int n = 0; n < 600; n++) begin
         drive(($urandom % 8) != 0,
               5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 2'($urandom),
               5'($urandom_range(0, 4)), ($urandom % 4) != 0, ($urandom % 2) == 0,
               ($urandom % 8) == 0, ($urandom % 64) == 0);
         tick();
      end

      nop();
      tick();
      @(negedge clk);
      #1;
      chk("sb_drain", 0, 8'(sb.size()), 8'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
